// File: rtl/fft_pkg.sv
// Shared types and helpers for the 8-point streaming FFT: FSM states,
// the sqrt(1/2) twiddle constant for a given sample width, and 3-bit bit reversal.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ST1,
    ST2,
    ST3,
    UNLOAD
  } state_t;

  // round(0.70710678 * 2^(w-1)), derived from the same constant held at 2^31 scale
  function automatic logic [31:0] twiddle_c(input int w);
    logic [63:0] base;
    int          sh;
    base = 64'd1518500250;
    sh   = 32 - w;
    if (sh > 0) twiddle_c = 32'((base + (64'd1 << (sh - 1))) >> sh);
    else        twiddle_c = base[31:0];
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// One radix-2 DIT butterfly with twiddle W8^k (k=0..3), optional conjugation and /2 scaling.
// Purely combinational; sums wrap at W+1 bits, no saturation.
module fft_bfly
  import fft_pkg::*;
#(
  parameter int W     = 16,
  parameter int SCALE = 1
) (
  input  logic signed [W-1:0] a_r,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_r,
  input  logic signed [W-1:0] b_i,
  input  logic        [1:0]   k,
  input  logic                inv,
  output logic signed [W-1:0] sum_r,
  output logic signed [W-1:0] sum_i,
  output logic signed [W-1:0] dif_r,
  output logic signed [W-1:0] dif_i
);

  localparam int                  PW = 2 * W + 2;
  localparam logic signed [W-1:0] CW = W'(twiddle_c(W));

  logic signed [W:0]    ar, ai, br, bi;
  logic signed [W:0]    bsum, bdif, csum, cdif;
  logic signed [W:0]    t_r, t_i;
  logic signed [W:0]    s_r, s_i, d_r, d_i;
  logic signed [PW-1:0] m_sum, m_dif;

  assign ar = {a_r[W-1], a_r};
  assign ai = {a_i[W-1], a_i};
  assign br = {b_r[W-1], b_r};
  assign bi = {b_i[W-1], b_i};

  // Diagonal twiddles factor as C*(br+bi) and C*(bi-br); operands are sign-extended to PW
  assign bsum  = br + bi;
  assign bdif  = bi - br;
  assign m_sum = {{(PW - W - 1){bsum[W]}}, bsum} * {{(PW - W){CW[W-1]}}, CW};
  assign m_dif = {{(PW - W - 1){bdif[W]}}, bdif} * {{(PW - W){CW[W-1]}}, CW};
  assign csum  = (W + 1)'(m_sum >>> (W - 1));
  assign cdif  = (W + 1)'(m_dif >>> (W - 1));

  always_comb begin
    t_r = br;
    t_i = bi;
    case (k)
      2'd1: begin
        t_r = inv ? -cdif : csum;
        t_i = inv ? csum  : cdif;
      end
      2'd2: begin
        t_r = inv ? -bi : bi;
        t_i = inv ? br  : -br;
      end
      2'd3: begin
        t_r = inv ? -csum : cdif;
        t_i = inv ? -cdif : -csum;
      end
      default: ;
    endcase
  end

  assign s_r = ar + t_r;
  assign s_i = ai + t_i;
  assign d_r = ar - t_r;
  assign d_i = ai - t_i;

  assign sum_r = (SCALE != 0) ? s_r[W:1] : s_r[W-1:0];
  assign sum_i = (SCALE != 0) ? s_i[W:1] : s_i[W-1:0];
  assign dif_r = (SCALE != 0) ? d_r[W:1] : d_r[W-1:0];
  assign dif_i = (SCALE != 0) ? d_i[W:1] : d_i[W-1:0];

endmodule

// File: rtl/fft_8_stream.sv
// Streaming 8-point radix-2 DIT FFT: load 8 samples bit-reversed, 3 in-place stages, unload 8 bins.
// First bin 4 cycles after x7 is accepted; input stalls while busy, output holds while out_ready=0.
module fft_8_stream
  import fft_pkg::*;
#(
  parameter int W     = 16,
  parameter int SCALE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_r,
  input  logic signed [W-1:0] in_i,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_r,
  output logic signed [W-1:0] out_i,
  output logic        [2:0]   out_idx,
  output logic                out_last,
  output logic                busy
);

  state_t state, state_nxt;

  logic [3:0] cnt;
  logic [2:0] idx;
  logic       inv_q;
  logic       live;
  logic       in_fire, out_fire, stage_en;
  logic [2:0] wr_addr;

  logic signed [W-1:0] buf_r [8];
  logic signed [W-1:0] buf_i [8];

  logic        [2:0]   top_a [4];
  logic        [2:0]   bot_a [4];
  logic        [1:0]   tw_k  [4];
  logic signed [W-1:0] ba_r [4];
  logic signed [W-1:0] ba_i [4];
  logic signed [W-1:0] bb_r [4];
  logic signed [W-1:0] bb_i [4];
  logic signed [W-1:0] s_r  [4];
  logic signed [W-1:0] s_i  [4];
  logic signed [W-1:0] d_r  [4];
  logic signed [W-1:0] d_i  [4];

  // cnt==8 is the commit cycle after x7: no more input, stages start next edge
  assign in_ready  = live && ((state == IDLE) || ((state == LOAD) && (cnt != 4'd8)));
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == UNLOAD);
  assign out_fire  = out_valid && out_ready;
  assign out_r     = out_valid ? buf_r[idx] : '0;
  assign out_i     = out_valid ? buf_i[idx] : '0;
  assign out_idx   = idx;
  assign out_last  = out_valid && (idx == 3'd7);
  assign busy      = (state != IDLE);
  assign stage_en  = (state == ST1) || (state == ST2) || (state == ST3);
  assign wr_addr   = bitrev3((state == IDLE) ? 3'd0 : cnt[2:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire) state_nxt = LOAD;
      LOAD:    if (cnt == 4'd8) state_nxt = ST1;
      ST1:     state_nxt = ST2;
      ST2:     state_nxt = ST3;
      ST3:     state_nxt = UNLOAD;
      UNLOAD:  if (out_fire && (idx == 3'd7)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      inv_q <= 1'b0;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (in_fire) begin
        cnt <= (state == IDLE) ? 4'd1 : cnt + 4'd1;
        if (state == IDLE) inv_q <= in_inv;
      end else if ((state == LOAD) && (cnt == 4'd8)) begin
        cnt <= '0;
      end
      if (out_fire) idx <= idx + 3'd1;
    end
  end

  // Span 1, 2, 4 pairings; twiddle exponent is position-in-group scaled to W8
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      top_a[j] = 3'(2 * j);
      bot_a[j] = 3'(2 * j + 1);
      tw_k[j]  = 2'd0;
      case (state)
        ST2: begin
          top_a[j] = {j[1], 1'b0, j[0]};
          bot_a[j] = {j[1], 1'b1, j[0]};
          tw_k[j]  = {j[0], 1'b0};
        end
        ST3: begin
          top_a[j] = {1'b0, j[1:0]};
          bot_a[j] = {1'b1, j[1:0]};
          tw_k[j]  = j[1:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      ba_r[j] = buf_r[top_a[j]];
      ba_i[j] = buf_i[top_a[j]];
      bb_r[j] = buf_r[bot_a[j]];
      bb_i[j] = buf_i[bot_a[j]];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bfly
    fft_bfly #(
      .W    (W),
      .SCALE(SCALE)
    ) u_bfly (
      .a_r  (ba_r[g]),
      .a_i  (ba_i[g]),
      .b_r  (bb_r[g]),
      .b_i  (bb_i[g]),
      .k    (tw_k[g]),
      .inv  (inv_q),
      .sum_r(s_r[g]),
      .sum_i(s_i[g]),
      .dif_r(d_r[g]),
      .dif_i(d_i[g])
    );
  end

  // Sample buffer is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_r[wr_addr] <= in_r;
      buf_i[wr_addr] <= in_i;
    end else if (stage_en) begin
      for (int j = 0; j < 4; j++) begin
        buf_r[top_a[j]] <= s_r[j];
        buf_i[top_a[j]] <= s_i[j];
        buf_r[bot_a[j]] <= d_r[j];
        buf_i[bot_a[j]] <= d_i[j];
      end
    end
  end

endmodule

// File: tb/tb_fft_8_stream.sv
// Bench for fft_8_stream: fixed vectors, random frames against a floating-point DFT,
// backpressure, mid-frame reset and an unscaled 8-bit wrap instance.
module tb_fft_8_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-bit scaled instance
  logic               v16, rdy16, inv16, ov16, ordy16, last16, busy16;
  logic signed [15:0] r16, i16, or16, oi16;
  logic        [2:0]  idx16;
  // 8-bit unscaled instance
  logic               v8, rdy8, inv8, ov8, ordy8, last8, busy8;
  logic signed [7:0]  r8, i8, or8, oi8;
  logic        [2:0]  idx8;

  fft_8_stream #(.W(16), .SCALE(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_r(r16), .in_i(i16),
    .in_inv(inv16), .out_valid(ov16), .out_ready(ordy16), .out_r(or16), .out_i(oi16),
    .out_idx(idx16), .out_last(last16), .busy(busy16));

  fft_8_stream #(.W(8), .SCALE(0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_r(r8), .in_i(i8),
    .in_inv(inv8), .out_valid(ov8), .out_ready(ordy8), .out_r(or8), .out_i(oi8),
    .out_idx(idx8), .out_last(last8), .busy(busy8));

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input longint act, input longint exp, input int tol);
    ntot++;
    if (act >= exp - tol && act <= exp + tol) npass++;
    else $display("FAIL %s: got %0d, want %0d (tol %0d)", nm, act, exp, tol);
  endtask

  typedef struct {
    string nm;
    int    xr[8];
    int    xi[8];
    bit    inv;
    int    er[8];
    int    ei[8];
    int    tol;
  } vec_t;

  vec_t tbl[4];

  task automatic push16(input int r, input int i, input bit inv, input int gaps, output int acc_cyc);
    int n;
    v16 = 1'b0;
    repeat (gaps) @(negedge clk);
    @(negedge clk);
    v16 = 1'b1; r16 = 16'(r); i16 = 16'(i); inv16 = inv;
    n = 0;
    while (!rdy16 && n < 40) begin @(negedge clk); n++; end
    if (!rdy16) chk("push_ready_timeout", rdy16, 1, 0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    v16 = 1'b0;
  endtask

  // Sample 0 carries the frame mode; later samples get a random in_inv that must be ignored
  task automatic send16(input int xr[8], input int xi[8], input bit inv, input int gapmax,
                        input int nsamp, output int acc7);
    for (int n = 0; n < nsamp; n++)
      push16(xr[n], xi[n], (n == 0) ? inv : 1'($urandom), (gapmax == 0) ? 0 : $urandom_range(0, gapmax), acc7);
  endtask

  task automatic pull16(input int stall_bin, input int stall_len,
                        output int gr[8], output int gi[8], output int first_cyc);
    int n, b, hold;
    logic signed [15:0] sr, si;
    b = 0; n = 0; hold = 0; first_cyc = -1; sr = '0; si = '0;
    ordy16 = 1'b0;
    while (b < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (ov16) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (b == stall_bin && hold < stall_len) begin
          if (hold == 0) begin
            sr = or16; si = oi16;
          end else begin
            chk("stall_r", or16, sr, 0);
            chk("stall_i", oi16, si, 0);
            chk("stall_idx", idx16, b, 0);
            chk("stall_rdy", rdy16, 0, 0);
          end
          hold++;
          ordy16 = 1'b0;
        end else begin
          gr[b] = or16; gi[b] = oi16;
          chk($sformatf("idx%0d", b), idx16, b, 0);
          chk($sformatf("last%0d", b), last16, (b == 7) ? 1 : 0, 0);
          chk($sformatf("rdy_unload%0d", b), rdy16, 0, 0);
          ordy16 = 1'b1;
          b++;
        end
      end else begin
        ordy16 = 1'b0;
      end
    end
    if (b < 8) chk("unload_timeout_bins", b, 8, 0);
    @(negedge clk);
    ordy16 = 1'b0;
    chk("rdy_after_last", rdy16, 1, 0);
    chk("idle_after_last", busy16, 0, 0);
  endtask

  // Direct DFT in floating point, divided by 8 for the scaled instance
  task automatic cmp_model(input string nm, input int xr[8], input int xi[8], input bit inv,
                           input int gr[8], input int gi[8]);
    real yr, yi, ang;
    for (int k = 0; k < 8; k++) begin
      yr = 0.0; yi = 0.0;
      for (int n = 0; n < 8; n++) begin
        ang = (inv ? 2.0 : -2.0) * 3.14159265358979 * k * n / 8.0;
        yr += xr[n] * $cos(ang) - xi[n] * $sin(ang);
        yi += xr[n] * $sin(ang) + xi[n] * $cos(ang);
      end
      chk($sformatf("%s_X%0d_r", nm, k), gr[k], longint'(yr / 8.0), 3);
      chk($sformatf("%s_X%0d_i", nm, k), gi[k], longint'(yi / 8.0), 3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench stuck at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc7, fc, stall;
    int gr[8], gi[8], xr[8], xi[8];
    int tone[8];
    bit inv;

    v16 = 0; r16 = 0; i16 = 0; inv16 = 0; ordy16 = 0;
    v8 = 0; r8 = 0; i8 = 0; inv8 = 0; ordy8 = 0;

    #1 rst = 1'b0;
    #2;
    chk("rst_in_ready", rdy16, 0, 0);
    chk("rst_out_valid", ov16, 0, 0);
    chk("rst_out_last", last16, 0, 0);
    chk("rst_busy", busy16, 0, 0);
    chk("rst_out_idx", idx16, 0, 0);
    chk("rst_out_r", or16, 0, 0);
    chk("rst_out_i", oi16, 0, 0);
    chk("rst_in_ready8", rdy8, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rdy_before_edge", rdy16, 0, 0);
    @(posedge clk);
    #1 chk("rdy_after_edge", rdy16, 1, 0);

    // Tone amplitude A gives A*N/2 in bins 1 and 7, then /8 from scaling
    tone = '{4096, 2896, 0, -2896, -4096, -2896, 0, 2896};
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 8; n++) begin
        tbl[t].xi[n] = 0; tbl[t].er[n] = 0; tbl[t].ei[n] = 0;
      end
    end
    tbl[0].nm = "impulse"; tbl[0].inv = 0; tbl[0].tol = 0;
    for (int n = 0; n < 8; n++) begin
      tbl[0].xr[n] = (n == 0) ? 1000 : 0; tbl[0].er[n] = 125;
    end
    tbl[1].nm = "dc"; tbl[1].inv = 0; tbl[1].tol = 0;
    for (int n = 0; n < 8; n++) tbl[1].xr[n] = 800;
    tbl[1].er[0] = 800;
    for (int t = 2; t < 4; t++) begin
      tbl[t].nm = (t == 2) ? "tone_fwd" : "tone_inv";
      tbl[t].inv = (t == 3); tbl[t].tol = 2;
      for (int n = 0; n < 8; n++) tbl[t].xr[n] = tone[n];
      tbl[t].er[1] = 2048; tbl[t].er[7] = 2048;
    end

    for (int t = 0; t < 4; t++) begin
      send16(tbl[t].xr, tbl[t].xi, tbl[t].inv, 0, 8, acc7);
      pull16(-1, 0, gr, gi, fc);
      chk($sformatf("%s_latency", tbl[t].nm), fc - acc7, 4, 0);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("%s_X%0d_r", tbl[t].nm, k), gr[k], tbl[t].er[k], tbl[t].tol);
        chk($sformatf("%s_X%0d_i", tbl[t].nm, k), gi[k], tbl[t].ei[k], tbl[t].tol);
      end
    end

    // Random frames, some gapped, one with a 5-cycle stall at bin 3
    for (int f = 0; f < 6; f++) begin
      for (int n = 0; n < 8; n++) begin
        xr[n] = int'($urandom_range(0, 8191)) - 4096;
        xi[n] = int'($urandom_range(0, 8191)) - 4096;
      end
      inv = 1'($urandom);
      stall = (f == 2) ? 3 : -1;
      send16(xr, xi, inv, (f % 2 == 1) ? 3 : 0, 8, acc7);
      pull16(stall, 5, gr, gi, fc);
      chk($sformatf("rand%0d_latency", f), fc - acc7, 4, 0);
      cmp_model($sformatf("rand%0d", f), xr, xi, inv, gr, gi);
    end

    // Gapped partial frame, then reset after x4
    for (int n = 0; n < 8; n++) begin
      xr[n] = int'($urandom_range(0, 8191)) - 4096;
      xi[n] = int'($urandom_range(0, 8191)) - 4096;
    end
    send16(xr, xi, 1'b0, 3, 5, acc7);
    #2 chk("busy_mid_load", busy16, 1, 0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", rdy16, 0, 0);
    chk("midrst_busy", busy16, 0, 0);
    chk("midrst_out_valid", ov16, 0, 0);
    chk("midrst_out_idx", idx16, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("midrst_rdy_after_edge", rdy16, 1, 0);
    for (int n = 0; n < 8; n++) begin
      xr[n] = int'($urandom_range(0, 8191)) - 4096;
      xi[n] = int'($urandom_range(0, 8191)) - 4096;
    end
    inv = 1'($urandom);
    send16(xr, xi, inv, 2, 8, acc7);
    pull16(-1, 0, gr, gi, fc);
    cmp_model("after_rst", xr, xi, inv, gr, gi);

    // Unscaled 8-bit: eight samples of 100 sum to 800, which wraps to 32
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk($sformatf("w8_rdy%0d", n), rdy8, 1, 0);
      v8 = 1'b1; r8 = 8'sd100; i8 = 8'sd0; inv8 = 1'b0;
      @(posedge clk);
      #1 v8 = 1'b0;
    end
    begin
      int b, n;
      b = 0; n = 0;
      ordy8 = 1'b1;
      while (b < 8 && n < 40) begin
        @(negedge clk);
        n++;
        if (ov8) begin
          chk($sformatf("w8_idx%0d", b), idx8, b, 0);
          chk($sformatf("w8_X%0d_r", b), or8, (b == 0) ? 32 : 0, 0);
          chk($sformatf("w8_X%0d_i", b), oi8, 0, 0);
          b++;
        end
      end
      if (b < 8) chk("w8_unload_timeout_bins", b, 8, 0);
      ordy8 = 1'b0;
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
